// File: rtl/lab2_proc_pkg.sv
// Shared types for the X-stage iterative multiplier.
// Function codes match the RV32M funct3 low bits.
package lab2_proc_pkg;

  typedef enum logic [1:0] {
    MUL_FN_MUL    = 2'd0,
    MUL_FN_MULH   = 2'd1,
    MUL_FN_MULHSU = 2'd2,
    MUL_FN_MULHU  = 2'd3
  } mul_fn_e;

  typedef enum logic [1:0] {
    MUL_STATE_IDLE = 2'd0,
    MUL_STATE_CALC = 2'd1,
    MUL_STATE_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_ITERS = 32;

  function automatic logic [31:0] mag32(
    input logic [31:0] v
  );
    // Two's complement wraps 0x80000000 to itself,
    // which is the correct unsigned magnitude.
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/proc_dpath_int_mul_iter_ctrl.sv
// Multiplier sequencer: IDLE -> CALC (fixed 32 steps)
// -> DONE, with load/step strobes for the datapath.
module proc_dpath_int_mul_iter_ctrl
  import lab2_proc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic istream_val,
  output logic istream_rdy,
  output logic ostream_val,
  input  logic ostream_rdy,
  output logic load,
  output logic step
);

  localparam logic [5:0] CNT_LAST =
    6'(MUL_ITERS - 1);

  mul_state_e state_q;
  logic [5:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MUL_STATE_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      unique case (state_q)
        MUL_STATE_IDLE: begin
          if (istream_val) begin
            state_q <= MUL_STATE_CALC;
            cnt_q   <= 6'd0;
          end
        end
        MUL_STATE_CALC: begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == CNT_LAST)
            state_q <= MUL_STATE_DONE;
        end
        MUL_STATE_DONE: begin
          if (ostream_rdy)
            state_q <= MUL_STATE_IDLE;
        end
        default: state_q <= MUL_STATE_IDLE;
      endcase
    end
  end

  assign istream_rdy =
    (state_q == MUL_STATE_IDLE) && !reset;
  assign ostream_val =
    (state_q == MUL_STATE_DONE) && !reset;
  assign load = istream_val && istream_rdy;
  assign step =
    (state_q == MUL_STATE_CALC) && !reset;

endmodule

// File: rtl/proc_dpath_int_mul_iter.sv
// Iterative 32x32 shift-add multiplier for MUL/MULH/
// MULHSU/MULHU: magnitudes multiplied, sign fixed after.
module proc_dpath_int_mul_iter
  import lab2_proc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [31:0] istream_a,
  input  logic [31:0] istream_b,
  input  logic [1:0]  istream_fn,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [31:0] ostream_msg
);

  logic load;
  logic step;

  proc_dpath_int_mul_iter_ctrl u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .load        (load),
    .step        (step)
  );

  mul_fn_e     fn_in;
  logic        sgn_a;
  logic        sgn_b;

  mul_fn_e     fn_q,  fn_d;
  logic        neg_q, neg_d;
  logic [63:0] a_q,   a_d;
  logic [31:0] b_q,   b_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] prod;

  assign fn_in = mul_fn_e'(istream_fn);
  assign sgn_a = (fn_in == MUL_FN_MULH) ||
                 (fn_in == MUL_FN_MULHSU);
  assign sgn_b = (fn_in == MUL_FN_MULH);

  always_comb begin
    fn_d  = fn_q;
    neg_d = neg_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (load) begin
      fn_d  = fn_in;
      neg_d = (sgn_a & istream_a[31]) ^
              (sgn_b & istream_b[31]);
      a_d   = {32'd0, sgn_a ? mag32(istream_a)
                            : istream_a};
      b_d   = sgn_b ? mag32(istream_b) : istream_b;
      acc_d = 64'd0;
    end else if (step) begin
      if (b_q[0])
        acc_d = acc_q + a_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q  <= MUL_FN_MUL;
      neg_q <= 1'b0;
      a_q   <= 64'd0;
      b_q   <= 32'd0;
      acc_q <= 64'd0;
    end else begin
      fn_q  <= fn_d;
      neg_q <= neg_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign prod = neg_q ? (~acc_q + 64'd1) : acc_q;

  always_comb begin
    ostream_msg = 32'd0;
    if (ostream_val)
      ostream_msg = (fn_q == MUL_FN_MUL)
                  ? prod[31:0] : prod[63:32];
  end

endmodule

// File: doc/proc_dpath_int_mul_iter.md
# proc_dpath_int_mul_iter

Iterative 32×32 integer multiplier. It sits in the X stage beside the processor ALU and implements RV32M MUL, MULH, MULHSU and MULHU. Operands arrive from the D stage over a val/rdy stream. Each operation takes a fixed 32 shift-add iterations, and the 32-bit result is presented on an output val/rdy stream to the X-stage result mux.

## Interface
- No parameters; data width is fixed at 32 bits.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `istream_val` input 1: operand request valid.
- `istream_rdy` output 1: unit can accept a request.
- `istream_a` input 32: multiplicand (rs1).
- `istream_b` input 32: multiplier (rs2).
- `istream_fn` input 2: operation select. 0 = MUL, 1 = MULH, 2 = MULHSU, 3 = MULHU.
- `ostream_val` output 1: result valid.
- `ostream_rdy` input 1: consumer accepts the result.
- `ostream_msg` output 32: result.

## Operation
- **States**
  - IDLE: `istream_rdy` = 1.
  - CALC: 32 iterations.
  - DONE: `ostream_val` = 1.
- **Accept.** A request is accepted when `istream_val && istream_rdy` at a rising edge while in IDLE. On acceptance, latch the following:
  - `fn`.
  - `neg` = sign(a)·signed_a XOR sign(b)·signed_b. signed_a is set for fn 1 and 2; signed_b is set for fn 1 only.
  - `a_reg[63:0]` = zero-extended |a|, taking the magnitude only if signed_a, otherwise a raw.
  - `b_reg[31:0]` = |b| if signed_b, else b raw.
  - `acc[63:0]` = 0.
  - `cnt[5:0]` = 0.
- **Signedness for MUL.** MUL treats both operands as unsigned, because the low word is sign-independent.
- **Magnitude of 0x80000000.** |0x80000000| = 0x80000000 as unsigned. This must be handled correctly.
- **CALC, every cycle:**
  - If `b_reg[0]`, then `acc` += `a_reg` (64-bit, modulo 2^64).
  - `a_reg` <<= 1.
  - `b_reg` >>= 1.
  - `cnt`++.
  - When `cnt` == 31 in CALC, the next state is DONE.
- **Early exit.** There is none. Latency is fixed even when `b_reg` reaches 0 early.
- **DONE output.**
  - `prod` = neg ? (~acc + 1) : acc.
  - `ostream_msg` = `prod[31:0]` for MUL, otherwise `prod[63:32]`.
- **DONE exit.** Go to IDLE when `ostream_rdy` = 1. Otherwise hold.
- **Back-to-back.** No new request is accepted in the same cycle as a result handoff. The next accept happens in IDLE at the earliest.

## Timing
- **Reset values.** While `reset` is high:
  - `istream_rdy` = 0.
  - `ostream_val` = 0.
  - `ostream_msg` = 0.
  - After reset is released, state = IDLE.
- **Latency.** If the handshake occurs at edge E, CALC occupies the 32 cycles after E, and `ostream_val` rises in the 33rd cycle after E.
- **Throughput.** One operation per 34 cycles minimum: accept, 32 CALC, 1 DONE.
- **Signal derivation.**
  - `istream_rdy` = (state == IDLE) && !reset, combinational from state.
  - `ostream_val` = (state == DONE).
- **Stability in DONE.** While `ostream_rdy` = 0, `ostream_msg` stays stable and `istream_rdy` stays 0.
- **Input side effects.** `istream_a`, `istream_b` and `istream_fn` are ignored outside the accept cycle. `istream_val` asserted while not ready has no effect.
- **Reset mid-operation.** Reset in CALC or DONE aborts the operation. The result is discarded with no output handshake, and the unit returns to IDLE on the first cycle after reset deasserts.

## Structure
- **Shared package** (lab2_proc package):
  - fn encoding enum: `MUL_FN_MUL`, `MUL_FN_MULH`, `MUL_FN_MULHSU`, `MUL_FN_MULHU`.
  - State enum: `MUL_STATE_IDLE`, `MUL_STATE_CALC`, `MUL_STATE_DONE`.
  - Iteration count constant: 32.
- **Sub-module.** The design splits naturally into `proc_dpath_int_mul_iter_ctrl`, which holds the FSM and `cnt` and produces the load, step and done controls. The parent holds the `a_reg`/`b_reg`/`acc` datapath and the sign fix-up.

## Test plan
- **MUL small.** MUL a=5, b=3, `ostream_rdy`=1.
  - `ostream_msg` = 0x0000000F.
  - `ostream_val` high exactly 33 cycles after the accept edge, for 1 cycle.
  - `istream_rdy` returns to 1 the cycle after.
- **All ones across functions.** a = b = 0xFFFFFFFF:
  - MUL → 0x00000001.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
  - MULHU → 0xFFFFFFFE.
- **Most-negative operand.**
  - MULH a = b = 0x80000000 → 0x40000000.
  - MUL 0x80000000 × 2 → 0x00000000.
  - MULH 0x80000000 × 0x00000001 → 0xFFFFFFFF.
- **Backpressure.** MUL 0xDEADBEEF × 0x10 with `ostream_rdy`=0 for 5 cycles in DONE.
  - `ostream_msg` holds 0xEADBEEF0 throughout.
  - `istream_rdy` stays 0.
  - `istream_val` pulses during this window are not accepted.
- **Reset mid-operation.** Assert `reset` for 1 cycle at CALC iteration 10 of MULHU 7×9.
  - `ostream_val` never rises for that operation.
  - `istream_rdy` = 1 the cycle after reset drops.
  - A following MUL 7×9 returns 0x0000003F.
- **Back-to-back stream.** 4 requests with `istream_val` held high (MUL 2×3, MULH -2×3, MULHSU -1×2, MULHU 0x10000×0x10000).
  - Results in order: 6, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001.
  - Accept edges spaced by 34 cycles.
